// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit driving a split address/data handshake bus.
// Multi-cycle: holds the pipeline via stall, owns the LL/SC link bit, detects alignment faults.
module mem_access_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3:0]          in_op,
  input  logic [ADDR_W-1:0]   in_addr,
  input  logic [DATA_W-1:0]   in_wdata,
  input  logic                flush,
  input  logic                llbit_clr,
  output logic                data_req,
  output logic                data_wr,
  output logic [1:0]          data_size,
  output logic [ADDR_W-1:0]   data_addr,
  output logic [DATA_W-1:0]   data_wdata,
  output logic [DATA_W/8-1:0] data_wstrb,
  input  logic                data_addr_ok,
  input  logic                data_data_ok,
  input  logic [DATA_W-1:0]   data_rdata,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_result,
  output logic [1:0]          out_exc,
  output logic [ADDR_W-1:0]   out_badvaddr,
  output logic                stall
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_t;

  typedef enum logic [3:0] {
    OP_LB = 4'd0, OP_LBU = 4'd1, OP_LH = 4'd2, OP_LHU = 4'd3, OP_LW = 4'd4,
    OP_LWU = 4'd5, OP_LD = 4'd6, OP_SB = 4'd7, OP_SH = 4'd8, OP_SW = 4'd9,
    OP_SD = 4'd10, OP_LL = 4'd11, OP_SC = 4'd12
  } op_t;

  function automatic logic [1:0] op_size(input logic [3:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: op_size = 2'd0;
      OP_LH, OP_LHU, OP_SH: op_size = 2'd1;
      OP_LD, OP_SD:         op_size = 2'd3;
      default:              op_size = 2'd2;
    endcase
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    op_is_store = (op == OP_SB) || (op == OP_SH) || (op == OP_SW) ||
                  (op == OP_SD) || (op == OP_SC);
  endfunction

  // Doubleword and zero-extended word ops only exist on a 64-bit datapath.
  function automatic logic op_legal(input logic [3:0] op);
    op_legal = (op <= OP_SC) &&
               !((DATA_W == 32) && ((op == OP_LWU) || (op == OP_LD) || (op == OP_SD)));
  endfunction

  function automatic logic misaligned(input logic [3:0] op, input logic [2:0] a);
    case (op_size(op))
      2'd1:    misaligned = a[0];
      2'd2:    misaligned = (a[1:0] != 2'b00);
      2'd3:    misaligned = (a != 3'b000);
      default: misaligned = 1'b0;
    endcase
  endfunction

  state_t              state_q, state_d;
  logic [3:0]          op_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                llbit_q;

  logic                load_regs, bus_done, done, ll_done, sc_done;
  logic [DATA_W-1:0]   done_res, bus_res, rshift;
  logic [1:0]          done_exc;
  logic [ADDR_W-1:0]   done_bad;
  logic [OFF_W-1:0]    off;

  assign off      = addr_q[OFF_W-1:0];
  assign in_ready = (state_q == S_IDLE);
  assign stall    = (state_q != S_IDLE);
  assign data_req = (state_q == S_REQ);
  assign data_wr  = data_req && op_is_store(op_q);
  assign data_size = data_req ? op_size(op_q) : 2'd0;
  assign data_addr = data_req ? addr_q : '0;
  assign rshift   = data_rdata >> {off, 3'b000};

  always_comb begin
    data_wdata = '0;
    data_wstrb = '0;
    if (data_wr) begin
      case (op_size(op_q))
        2'd0: begin
          data_wdata = {STRB_W{wdata_q[7:0]}};
          data_wstrb = STRB_W'(1) << off;
        end
        2'd1: begin
          data_wdata = {(STRB_W/2){wdata_q[15:0]}};
          data_wstrb = STRB_W'(3) << off;
        end
        2'd2: begin
          data_wdata = {(DATA_W/32){wdata_q[31:0]}};
          data_wstrb = STRB_W'(15) << off;
        end
        default: begin
          data_wdata = wdata_q;
          data_wstrb = '1;
        end
      endcase
    end
  end

  always_comb begin
    case (op_q)
      OP_LB:        bus_res = DATA_W'($signed(rshift[7:0]));
      OP_LBU:       bus_res = DATA_W'(rshift[7:0]);
      OP_LH:        bus_res = DATA_W'($signed(rshift[15:0]));
      OP_LHU:       bus_res = DATA_W'(rshift[15:0]);
      OP_LW, OP_LL: bus_res = DATA_W'($signed(rshift[31:0]));
      OP_LWU:       bus_res = DATA_W'(rshift[31:0]);
      OP_LD:        bus_res = rshift;
      OP_SC:        bus_res = DATA_W'(1);
      default:      bus_res = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    load_regs = 1'b0;
    bus_done  = 1'b0;
    done      = 1'b0;
    done_res  = '0;
    done_exc  = 2'b00;
    done_bad  = '0;
    ll_done   = 1'b0;
    sc_done   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid && !flush) begin
          if (!op_legal(in_op)) begin
            done = 1'b1;
          end else if (misaligned(in_op, in_addr[2:0])) begin
            done     = 1'b1;
            done_exc = op_is_store(in_op) ? 2'b10 : 2'b01;
            done_bad = in_addr;
          end else if ((in_op == OP_SC) && !llbit_q) begin
            done    = 1'b1;
            sc_done = 1'b1;
          end else begin
            load_regs = 1'b1;
            state_d   = S_REQ;
          end
        end
      end
      S_REQ: begin
        // A flush coinciding with both handshakes has nothing left to drain.
        if (data_addr_ok) begin
          if (data_data_ok) begin
            state_d  = S_IDLE;
            bus_done = !flush;
          end else begin
            state_d = flush ? S_DRAIN : S_WAIT;
          end
        end else if (flush) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (data_data_ok) begin
          state_d  = S_IDLE;
          bus_done = !flush;
        end else if (flush) begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        if (data_data_ok) state_d = S_IDLE;
      end
    endcase
    if (bus_done) begin
      done     = 1'b1;
      done_res = bus_res;
      ll_done  = (op_q == OP_LL);
      sc_done  = (op_q == OP_SC);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      llbit_q      <= 1'b0;
      out_valid    <= 1'b0;
      out_result   <= '0;
      out_exc      <= 2'b00;
      out_badvaddr <= '0;
    end else begin
      state_q      <= state_d;
      out_valid    <= done;
      out_result   <= done_res;
      out_exc      <= done_exc;
      out_badvaddr <= done_bad;
      if (load_regs) begin
        op_q    <= in_op;
        addr_q  <= in_addr;
        wdata_q <= in_wdata;
      end
      if (llbit_clr)    llbit_q <= 1'b0;
      else if (ll_done) llbit_q <= 1'b1;
      else if (sc_done) llbit_q <= 1'b0;
    end
  end

endmodule
